mem_fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of the `mem` block (depth 100, 8-bit, registered read) and turns it into a first-in-first-out queue. It presents a valid/ready push port and a request/response pop port to the rest of the design. It generates `mem`'s `wr_en`/`wr_addr`/`wr_data` and `rd_en`/`rd_addr`, and forwards `rd_data` back as pop data with a validity strobe. It owns all pointer, occupancy and wrap-around logic; `mem` stays a plain storage array.

---
 rtl/mem_fifo_ctrl_pkg.sv | 28 ++
 rtl/mem_fifo_ctrl_wrap_ptr.sv | 42 ++++
 rtl/mem_fifo_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_fifo_ctrl_pkg.sv
// rtl/mem_fifo_ctrl_pkg.sv - shared types and helpers for the mem FIFO controller
//
// Purpose : occupancy-update encoding used by the top level.
// Contents: occ_op_e  - what the occupancy counter does this cycle
//           occ_op()  - decode accepted push/pop strobes into an occ_op_e

package mem_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

  // A push and a pop in the same cycle cancel out, so only a lone strobe
  // moves the counter.
  function automatic occ_op_e occ_op(input logic push_fire, input logic pop_fire);
    occ_op_e op;
    op = OCC_HOLD;
    case ({push_fire, pop_fire})
      2'b10:   op = OCC_INC;
      2'b01:   op = OCC_DEC;
      default: op = OCC_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_fifo_ctrl_wrap_ptr.sv
// rtl/mem_fifo_ctrl_wrap_ptr.sv - modulo-DEPTH pointer with increment enable
//
// Purpose : address pointer that counts 0..DEPTH-1 and wraps back to 0, so
//           non-power-of-two depths never produce an out-of-range address.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset, clears ptr to 0
//           inc    - advance the pointer on this posedge
//           ptr    - current pointer value (registered)

module wrap_ptr #(
  parameter int DEPTH  = 100,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller wrapped around an external registered-read mem
//
// Purpose : turns a plain DEPTH x DATA_W storage array (instantiated by the
//           parent) into a first-in-first-out queue. Owns pointers, occupancy
//           and wrap-around; mem only stores.
// Ports   : clk, rst_n                 - clock, asynchronous active-low reset
//           push_valid/push_data       - producer side
//           push_ready                 - FIFO can accept (0 while in reset)
//           pop_req                    - consumer asks for one entry
//           pop_ack                    - request accepted this cycle
//           pop_data/pop_data_valid    - dequeued word, one cycle after pop_ack
//           underflow                  - one-cycle pulse: pop_req while empty
//           count, full, empty         - occupancy state
//           mem_wr_en/addr/data        - to mem write port
//           mem_rd_en/addr             - to mem read port
//           mem_rd_data                - from mem, valid the cycle after rd_en

module mem_fifo_ctrl
  import mem_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ack,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_data_valid,
  output logic              underflow,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_d, count_q;
  logic              rd_pend_d, rd_pend_q;
  logic              underflow_d, underflow_q;
  logic              full_w, empty_w;
  logic              push_fire, pop_fire;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  occ_op_e           op;

  // Flags decode the registered count only, so they move on posedge alone.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // When full, a same-cycle pop does not free room for the push: the freed
  // slot only becomes visible after the posedge, so push_ready stays low.
  // When empty, the pop is refused outright because mem reads are registered
  // and a bypass path would break the one-cycle read latency contract.
  always_comb begin
    push_fire   = push_valid && rst_n && !full_w;
    pop_fire    = pop_req && !empty_w;
    underflow_d = pop_req && empty_w;
    rd_pend_d   = pop_fire;
    op          = occ_op(push_fire, pop_fire);
    count_d     = count_q;
    case (op)
      OCC_INC: count_d = count_q + CNT_W'(1);
      OCC_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      underflow_q <= underflow_d;
    end
  end

  wrap_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_fire),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_fire),
    .ptr   (rd_ptr)
  );

  // Gating push_ready with rst_n keeps producers stalled while reset is held,
  // even though count already reads 0 (which would otherwise mean "not full").
  assign push_ready     = rst_n && !full_w;
  assign pop_ack        = pop_fire;
  assign full           = full_w;
  assign empty          = empty_w;
  assign count          = count_q;
  assign underflow      = underflow_q;

  assign mem_wr_en      = push_fire;
  assign mem_wr_addr    = wr_ptr;
  assign mem_wr_data    = push_data;
  assign mem_rd_en      = pop_fire;
  assign mem_rd_addr    = rd_ptr;

  // rd_pend is cleared by reset, so a read in flight across reset never
  // surfaces even if mem still returns a word.
  assign pop_data_valid = rd_pend_q;
  assign pop_data       = mem_rd_data;

endmodule
